rom_pic_reader: RTL and testbench
=================================

Name: rom_pic_reader

Overview:
- Drives the read port of the 16-bit-address, 24-bit-data picture ROM (256x256 RGB888, asynchronous-reset ROM, no output register) from the HDMI video timing.
- Places the stored picture in a window of the active area and paints background elsewhere.
- Outputs a latency-aligned RGB pixel stream with delayed syncs to the downstream median-filter stage.

Parameters:
- IMG_W, 256, picture width in pixels
- IMG_H, 256, picture height in lines; IMG_W*IMG_H must be <= 2^ADDR_WIDTH
- ADDR_WIDTH, 16, ROM address width
- DATA_WIDTH, 24, ROM data / pixel width (R[23:16], G[15:8], B[7:0])
- H_START, 0, first active pixel column of the window
- V_START, 0, first active line of the window
- BG_COLOR, 24'h000000, colour driven outside the window

Ports:
- clk  in  1  pixel clock; also clocks the ROM
- rst_n  in  1  asynchronous, active-low reset
- vs_in  in  1  vertical sync, active high
- hs_in  in  1  horizontal sync, active high
- de_in  in  1  data enable, active high
- rom_addr  out  ADDR_WIDTH  ROM address (registered)
- rom_data  in  DATA_WIDTH  ROM read data, valid one clk after rom_addr is sampled
- vs_out  out  1  vs_in delayed 3 clk
- hs_out  out  1  hs_in delayed 3 clk
- de_out  out  1  de_in delayed 3 clk
- rgb_out  out  DATA_WIDTH  pixel aligned with de_out
- frame_done  out  1  one-clk pulse when the last picture pixel is output

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0, including rgb_out (not BG_COLOR).
  - The x/y counters, address counter and pipeline are cleared.
  - frame_valid is cleared.
- Frame start is the rising edge of vs_in (registered edge detect).
  - Sets frame_valid, clears y and the address counter.
  - Until the first frame start after reset, in_win is forced to 0: background only, no ROM reads advance.
- x counter:
  - Increments on every clk with de_in=1.
  - Clears on the falling edge of de_in, which also increments y.
  - Both counters are 12 bits and saturate at 4095.
- in_win = frame_valid & de_in & (H_START <= x < H_START+IMG_W) & (V_START <= y < V_START+IMG_H).
- Stage 0 to 1 (edge 1):
  - If in_win, rom_addr <= addr_cnt, then addr_cnt advances.
  - addr_cnt wraps from IMG_W*IMG_H-1 to 0.
  - If not in_win, rom_addr holds.
  - vs/hs/de/in_win enter a 3-stage delay line.
- Stage 2 (edge 2): the ROM presents rom_data.
- Stage 3 (edge 3):
  - rgb_out <= in_win_d2 ? rom_data : (de_d2 ? BG_COLOR : 0).
  - vs/hs/de_out are updated.
- Total latency, input pixel to rgb_out/de_out: exactly 3 clk. Syncs keep the same alignment.
- frame_done:
  - Pulses with the rgb_out cycle of address IMG_W*IMG_H-1.
  - Does not pulse if the frame is truncated.
- Boundary conditions:
  - Window wider or taller than the active area: clipped. The address counter only advances on in_win pixels, so the remainder is never read and frame_done does not fire.
  - vs_in rising mid-frame: the address counter resets to 0 immediately; in-flight pipeline pixels still complete.
  - de_in falling and vs_in rising on the same clk: y clear has priority over y increment.
  - rst_n asserted mid-frame: outputs go to 0 at once. After release, output stays background/zero until the next vs_in rising edge.

Test Plan:
- Reset: hold rst_n=0 with random timing inputs -> all outputs 0. After release and before any vs rise, de_in pulses produce de_out=1, rgb_out=BG_COLOR, rom_addr=0.
- Small frame: 300x260 active, H_START=10, V_START=2, ROM model returns addr-based data -> first in_win pixel (x=10, y=2) gives rom_addr=0 one clk later and rgb_out=model(0) 3 clk later. Pixel (x=265, y=2) gives model(255). Pixel (x=266, y=2) gives BG_COLOR. frame_done is one pulse, aligned with addr 65535.
- Latency and syncs: random blanking widths -> vs_out/hs_out/de_out equal the inputs delayed exactly 3 clk every cycle, and rgb_out=0 whenever de_out=0.
- Wrap and small picture: IMG_W=4, IMG_H=2, window 4x2 over two frames -> addresses 0..7 then 0..7. frame_done fires twice. There is no address 8.
- Truncated frame: vs_in rises after 100 window lines -> no frame_done. Next frame's first window pixel reads addr 0.
- Mid-frame reset: assert rst_n=0 for 5 clk during line 50 -> outputs 0 during reset. Background only until the next vs rise. The following frame reads 0..65535 normally with one frame_done.

Source files
------------

// File: rtl/rom_pic_reader.sv
// rom_pic_reader: windowed picture-ROM reader driven by video timing, 3-clk aligned RGB/sync output
module rom_pic_reader #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 24,
   parameter int H_START = 0,
   parameter int V_START = 0,
   parameter logic [DATA_WIDTH-1:0] BG_COLOR = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vs_in,
   input  logic                  hs_in,
   input  logic                  de_in,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  vs_out,
   output logic                  hs_out,
   output logic                  de_out,
   output logic [DATA_WIDTH-1:0] rgb_out,
   output logic                  frame_done
);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IMG_W * IMG_H - 1);
   logic vs_q, de_q, frame_valid;
   logic [11:0] x, y;
   logic [13:0] x_off, y_off;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic vs_rise, de_fall, in_win, last_pix;
   logic [1:0] vs_p, hs_p, de_p, win_p, last_p;
   // offset-and-compare avoids a constant-true lower bound when the window starts at 0
   always_comb begin
      vs_rise = vs_in & ~vs_q;
      de_fall = ~de_in & de_q;
      x_off = {2'b00, x} - 14'(H_START);
      y_off = {2'b00, y} - 14'(V_START);
      in_win = frame_valid & de_in & (x_off < 14'(IMG_W)) & (y_off < 14'(IMG_H));
      last_pix = in_win & (addr_cnt == LAST);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q <= 1'b0;
         de_q <= 1'b0;
         frame_valid <= 1'b0;
         x <= '0;
         y <= '0;
         addr_cnt <= '0;
         rom_addr <= '0;
         vs_p <= '0;
         hs_p <= '0;
         de_p <= '0;
         win_p <= '0;
         last_p <= '0;
         vs_out <= 1'b0;
         hs_out <= 1'b0;
         de_out <= 1'b0;
         rgb_out <= '0;
         frame_done <= 1'b0;
      end else begin
         vs_q <= vs_in;
         de_q <= de_in;
         if (vs_rise) frame_valid <= 1'b1;
         x <= de_in ? ((x == 12'hfff) ? x : x + 1'b1) : (de_fall ? '0 : x);
         y <= vs_rise ? '0 : (de_fall ? ((y == 12'hfff) ? y : y + 1'b1) : y);
         addr_cnt <= vs_rise ? '0 : (in_win ? (last_pix ? '0 : addr_cnt + 1'b1) : addr_cnt);
         if (in_win) rom_addr <= addr_cnt;
         vs_p <= {vs_p[0], vs_in};
         hs_p <= {hs_p[0], hs_in};
         de_p <= {de_p[0], de_in};
         win_p <= {win_p[0], in_win};
         last_p <= {last_p[0], last_pix};
         vs_out <= vs_p[1];
         hs_out <= hs_p[1];
         de_out <= de_p[1];
         rgb_out <= win_p[1] ? rom_data : (de_p[1] ? BG_COLOR : '0);
         frame_done <= last_p[1];
      end
   end
endmodule

// File: tb/tb_rom_pic_reader.sv
// tb_rom_pic_reader: three window configurations driven by one random timing stream, checked every cycle
module tb_rom_pic_reader;
   typedef struct packed {logic rst_n, vs, hs, de;} stim_t;
   typedef struct packed {logic vs, hs, de, win, last; logic [15:0] addr;} ent_t;
   logic clk = 1'b0, rst_n = 1'b0, vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
   logic [15:0] rom_addr [3];
   logic [23:0] rom_q [3], rgb [3];
   logic vs_o [3], hs_o [3], de_o [3], fd [3];
   int pw [3] = '{16, 4, 32};
   int ph [3] = '{8, 2, 16};
   int px0 [3] = '{3, 0, 5};
   int py0 [3] = '{2, 0, 4};
   logic [23:0] bg [3] = '{24'h123456, 24'h000000, 24'hABCDEF};
   int checks = 0, errors = 0, n_a = 0, n_b = 0;
   stim_t stim [$];
   bit fv [3], vsp [3], dep [3];
   int pix [3], ln [3], wcnt [3], fd_seen [3];
   logic [15:0] raddr [3];
   ent_t pipe [3][3];

   always #5 clk = ~clk;

   rom_pic_reader #(.IMG_W(16), .IMG_H(8), .H_START(3), .V_START(2), .BG_COLOR(24'h123456)) u_a (
      .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
      .rom_addr(rom_addr[0]), .rom_data(rom_q[0]), .vs_out(vs_o[0]), .hs_out(hs_o[0]),
      .de_out(de_o[0]), .rgb_out(rgb[0]), .frame_done(fd[0]));
   rom_pic_reader #(.IMG_W(4), .IMG_H(2), .H_START(0), .V_START(0)) u_b (
      .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
      .rom_addr(rom_addr[1]), .rom_data(rom_q[1]), .vs_out(vs_o[1]), .hs_out(hs_o[1]),
      .de_out(de_o[1]), .rgb_out(rgb[1]), .frame_done(fd[1]));
   rom_pic_reader #(.IMG_W(32), .IMG_H(16), .H_START(5), .V_START(4), .BG_COLOR(24'hABCDEF)) u_c (
      .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
      .rom_addr(rom_addr[2]), .rom_data(rom_q[2]), .vs_out(vs_o[2]), .hs_out(hs_o[2]),
      .de_out(de_o[2]), .rgb_out(rgb[2]), .frame_done(fd[2]));

   function automatic logic [23:0] rom_fn(input logic [15:0] a);
      logic [31:0] p;
      p = {16'd0, a} * 32'd40503 + 32'd12345;
      return p[23:0] ^ {a[7:0], a[15:8], a[7:0]};
   endfunction

   // synchronous-read ROM with asynchronous reset, one per DUT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) rom_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) rom_q[i] <= rom_fn(rom_addr[i]);
      end
   end

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   task automatic put(logic r, logic v, logic h, logic d, int n);
      repeat (n) stim.push_back({r, v, h, d});
   endtask

   task automatic gen_line(int w, bit tight, int rst_at);
      put(1'b1, 1'b0, 1'b1, 1'b0, 2);
      put(1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(1, 4));
      for (int i = 0; i < w; i++) put(!(rst_at >= 0 && i >= rst_at && i < rst_at + 5), 1'b0, 1'b0, 1'b1, 1);
      if (!tight) put(1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(1, 3));
   endtask

   task automatic gen_frame(int lines, bit tight, int rst_line);
      int w = $urandom_range(20, 26);
      put(1'b1, 1'b1, 1'b0, 1'b0, 2);
      put(1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(1, 3));
      for (int l = 0; l < lines; l++) gen_line(w, tight && l == lines - 1, l == rst_line ? w / 3 : -1);
   endtask

   // reference: window pixels counted since frame start, address is that count modulo picture size
   task automatic step(stim_t s);
      for (int d = 0; d < 3; d++) begin
         ent_t e;
         int n;
         e = '0;
         n = pw[d] * ph[d];
         if (!s.rst_n) begin
            fv[d] = 0; vsp[d] = 0; dep[d] = 0;
            pix[d] = 0; ln[d] = 0; wcnt[d] = 0; raddr[d] = '0;
            for (int k = 0; k < 3; k++) pipe[d][k] = '0;
         end else begin
            e.vs = s.vs; e.hs = s.hs; e.de = s.de;
            e.win = fv[d] && s.de && pix[d] >= px0[d] && pix[d] < px0[d] + pw[d]
                    && ln[d] >= py0[d] && ln[d] < py0[d] + ph[d];
            e.addr = 16'(wcnt[d] % n);
            e.last = e.win && (wcnt[d] % n) == n - 1;
            if (e.win) begin
               raddr[d] = e.addr;
               wcnt[d]++;
            end
            if (s.vs && !vsp[d]) begin
               fv[d] = 1; ln[d] = 0; wcnt[d] = 0;
            end else if (!s.de && dep[d]) ln[d]++;
            pix[d] = s.de ? pix[d] + 1 : 0;
            vsp[d] = s.vs;
            dep[d] = s.de;
            pipe[d][0] = pipe[d][1];
            pipe[d][1] = pipe[d][2];
            pipe[d][2] = e;
         end
      end
   endtask

   task automatic check_all(logic r);
      for (int d = 0; d < 3; d++) begin
         ent_t e;
         logic [23:0] xr;
         e = r ? pipe[d][0] : '0;
         xr = e.win ? rom_fn(e.addr) : (e.de ? bg[d] : 24'h0);
         chk($sformatf("addr%0d", d), {16'd0, rom_addr[d]}, {16'd0, r ? raddr[d] : 16'd0});
         chk($sformatf("rgb%0d", d), {8'd0, rgb[d]}, {8'd0, xr});
         chk($sformatf("vs%0d", d), {31'd0, vs_o[d]}, {31'd0, e.vs});
         chk($sformatf("hs%0d", d), {31'd0, hs_o[d]}, {31'd0, e.hs});
         chk($sformatf("de%0d", d), {31'd0, de_o[d]}, {31'd0, e.de});
         chk($sformatf("fd%0d", d), {31'd0, fd[d]}, {31'd0, e.last});
         if (fd[d] === 1'b1) fd_seen[d]++;
      end
   endtask

   initial begin
      for (int i = 0; i < 6; i++) put(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1);
      put(1'b1, 1'b0, 1'b0, 1'b0, 3);
      gen_line(22, 1'b0, -1);
      gen_line(22, 1'b0, -1);
      repeat (2) begin
         gen_frame($urandom_range(10, 13), 1'b0, -1);
         n_a++; n_b++;
      end
      gen_frame(5, 1'b1, -1);
      n_b++;
      gen_frame($urandom_range(10, 13), 1'b0, -1);
      n_a++; n_b++;
      gen_frame(12, 1'b0, 6);
      n_b++;
      gen_line(22, 1'b0, -1);
      gen_frame($urandom_range(10, 13), 1'b0, -1);
      n_a++; n_b++;
      put(1'b1, 1'b0, 1'b0, 1'b0, 8);
      for (int t = 0; t < stim.size(); t++) begin
         {rst_n, vs_in, hs_in, de_in} = stim[t];
         @(negedge clk);
         check_all(stim[t].rst_n);
         @(posedge clk);
         step(stim[t]);
         #1;
      end
      chk("fd_cnt_a", fd_seen[0], n_a);
      chk("fd_cnt_b", fd_seen[1], n_b);
      chk("fd_cnt_c", fd_seen[2], 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
